// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory slave.
//   state_t          frame FSM states
//   CMD_READ/WRITE   encodings of the R/W bit that closes the command phase
//   rw_bit_index()   bit-counter value at which the R/W bit is sampled
//   sample_on_rise() SPI mode -> 1 if MOSI is sampled on the SCLK rising edge
package spi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD_LOAD = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DONE    = 3'd5,
    ST_WAIT_CS = 3'd6
  } state_t;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  // The command is addr[ADDR_W-1:0] followed by R/W, so R/W is the bit
  // received when the counter equals ADDR_W.
  function automatic int rw_bit_index(input int addr_w);
    return addr_w;
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling
  // edge; the shift edge is always the opposite one.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with one-clk edge
// pulses derived from the synchronised level.
//   clk, rst_n  fabric clock, async active-low reset
//   pin         raw asynchronous pin
//   level       synchronised pin value
//   rise, fall  one-clk pulses on synchronised 0->1 / 1->0 transitions
// RESET_VAL should be the pin's expected idle level, so leaving reset does
// not fabricate an edge.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave fronting a word-addressed RAM of 2**ADDR_W x DATA_W.
// Frame: CS low, addr (MSB first), R/W bit (1 = read), then data words.
// Burst mode auto-increments the address (wrapping) across words.
//   clk, rst_n       fabric clock (>= 8x SCLK), async active-low reset
//   sclk_pin, cs_pin, mosi_pin   asynchronous SPI inputs
//   miso_pin, miso_oe            MISO data and output enable
//   busy             frame in progress
//   abort_count      saturating count of frames cut off mid-word
//   dbg_state        current FSM state (spi_mem_pkg::state_t encoding)
// Handshake: there is no valid/ready interface; the SPI master owns all
// timing and the slave follows synchronised SCLK edges, with a CS rise
// taking priority over any SCLK edge seen in the same clk.
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int BURST       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic [7:0] abort_count,
  output logic [2:0] dbg_state
);

  localparam int   MAXW        = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int   CNT_W       = $clog2(MAXW + 1);
  localparam logic SAMPLE_RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
  localparam logic [CNT_W-1:0] CNT_RW   = CNT_W'(rw_bit_index(ADDR_W));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // ---------------- pin synchronisers ----------------
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(sclk_pin),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CS resets to "asserted" so a CS held low through reset shows no fall
  // edge and the FSM parks in WAIT_CS instead of starting a bogus frame.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_pin),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin(mosi_pin),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_level, mosi_rise, mosi_fall};

  // ---------------- edge qualification ----------------
  logic sample_edge, shift_edge;
  assign sample_edge = (SAMPLE_RISE ? sclk_rise : sclk_fall) & ~cs_rise;
  assign shift_edge  = (SAMPLE_RISE ? sclk_fall : sclk_rise) & ~cs_rise;

  // ---------------- datapath registers ----------------
  state_t              state, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   cmd_shift;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-2:0]   rx_shift;
  logic [DATA_W-1:0]   rx_next;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   prefetch;
  logic [1:0]          pf_wait;
  logic [1:0]          load_phase;
  logic                miso_q;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   ram_q;

  logic rw_done, word_done;
  assign rw_done   = sample_edge && (bit_cnt == CNT_RW);
  assign word_done = sample_edge && (bit_cnt == CNT_LAST);
  assign rx_next   = {rx_shift, mosi_level};

  // ---------------- RAM ----------------
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Read port tracks addr+1 so the prefetch buffer can always be refilled;
  // only the first RD_LOAD cycle fetches the addressed word itself.
  assign rd_addr = (state == ST_RD_LOAD && load_phase == 2'd0) ? addr
                                                               : addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[rd_addr];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (cs_fall) state_next = ST_CMD;
                    else if (!cs_level) state_next = ST_WAIT_CS;
        ST_CMD:     if (rw_done)
                      state_next = (mosi_level == CMD_READ) ? ST_RD_LOAD : ST_WR_DATA;
        ST_RD_LOAD: if (load_phase == 2'd2) state_next = ST_RD_DATA;
        ST_RD_DATA: if (word_done && BURST == 0) state_next = ST_DONE;
        ST_WR_DATA: if (word_done && BURST == 0) state_next = ST_DONE;
        ST_DONE:    state_next = ST_DONE;
        ST_WAIT_CS: if (cs_level) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    miso_oe   = 1'b0;
    miso_pin  = 1'b0;
    busy      = 1'b0;
    dbg_state = state;
    if (state == ST_RD_DATA) begin
      miso_oe  = 1'b1;
      miso_pin = miso_q;
    end
    if (state inside {ST_CMD, ST_RD_LOAD, ST_RD_DATA, ST_WR_DATA, ST_DONE})
      busy = 1'b1;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      cmd_shift   <= '0;
      addr        <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      prefetch    <= '0;
      pf_wait     <= '0;
      load_phase  <= '0;
      miso_q      <= 1'b0;
      we          <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      abort_count <= '0;
    end else begin
      we <= 1'b0;

      // Refill the prefetch buffer two clks after an address step: one clk
      // for the new rd_addr to reach the RAM, one for the read latency.
      if (pf_wait != 2'd0) begin
        pf_wait <= pf_wait - 2'd1;
        if (pf_wait == 2'd1) prefetch <= ram_q;
      end

      if (cs_rise && (state inside {ST_CMD, ST_WR_DATA, ST_RD_DATA}) &&
          bit_cnt != '0 && abort_count != 8'hFF)
        abort_count <= abort_count + 8'd1;

      case (state)
        ST_IDLE: begin
          bit_cnt    <= '0;
          load_phase <= '0;
          pf_wait    <= '0;
        end
        ST_CMD: begin
          if (sample_edge) begin
            if (bit_cnt == CNT_RW) begin
              addr       <= cmd_shift;
              bit_cnt    <= '0;
              load_phase <= '0;
            end else begin
              cmd_shift <= {cmd_shift[ADDR_W-2:0], mosi_level};
              bit_cnt   <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_RD_LOAD: begin
          miso_q     <= 1'b0;
          load_phase <= load_phase + 2'd1;
          if (load_phase == 2'd1) tx_shift <= ram_q;
          if (load_phase == 2'd2) prefetch <= ram_q;
        end
        ST_RD_DATA: begin
          if (shift_edge) begin
            miso_q   <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
          // Word boundary is counted on sample edges so the master has
          // already captured the last bit before the next word is loaded.
          if (sample_edge) begin
            if (bit_cnt == CNT_LAST) begin
              bit_cnt  <= '0;
              tx_shift <= prefetch;
              addr     <= addr + ADDR_W'(1);
              pf_wait  <= 2'd2;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_WR_DATA: begin
          if (sample_edge) begin
            if (bit_cnt == CNT_LAST) begin
              we      <= 1'b1;
              waddr   <= addr;
              wdata   <= rx_next;
              addr    <= addr + ADDR_W'(1);
              bit_cnt <= '0;
            end else begin
              rx_shift <= rx_next[DATA_W-2:0];
              bit_cnt  <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
module tb_spi_mem_slave;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: mode 0, burst.  DUT 1: mode 3 (CPOL=1, CPHA=1), no burst.
  logic sclk0, cs0, mosi0;
  logic sclk1, cs1, mosi1;
  wire        miso0, oe0, busy0;
  wire        miso1, oe1, busy1;
  wire [7:0]  abort0, abort1;
  wire [2:0]  st0, st1;

  spi_mem_slave #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(0), .BURST(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk0), .cs_pin(cs0), .mosi_pin(mosi0),
    .miso_pin(miso0), .miso_oe(oe0), .busy(busy0), .abort_count(abort0), .dbg_state(st0)
  );

  spi_mem_slave #(.ADDR_W(7), .DATA_W(8), .CPOL(1), .CPHA(1), .BURST(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk1), .cs_pin(cs1), .mosi_pin(mosi1),
    .miso_pin(miso1), .miso_oe(oe1), .busy(busy1), .abort_count(abort1), .dbg_state(st1)
  );

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];
  int checks = 0;
  int errors = 0;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic half_period();
    repeat (5) @(negedge clk);
  endtask

  task automatic set_sclk(input int d, input logic v);
    if (d == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic set_mosi(input int d, input logic v);
    if (d == 0) mosi0 = v; else mosi1 = v;
  endtask

  function automatic logic get_miso(input int d);
    return (d == 0) ? miso0 : miso1;
  endfunction

  function automatic logic get_oe(input int d);
    return (d == 0) ? oe0 : oe1;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [7:0] get_abort(input int d);
    return (d == 0) ? abort0 : abort1;
  endfunction

  // One SPI frame of nbits, MSB first. rx/oe_bits hold MISO and miso_oe as
  // seen at each master sample point. If rst_bit >= 0, rst_n is pulsed at
  // the start of that bit while CS stays low; rst_snap captures
  // {miso, oe, busy, abort_count} during reset.
  task automatic spi_frame(input int d, input int nbits, input logic [31:0] tx,
                           input int rst_bit, output logic [31:0] rx,
                           output logic [31:0] oe_bits, output logic busy_mid,
                           output logic [10:0] rst_snap);
    logic cpol, cpha;
    cpol = (d == 1);
    cpha = (d == 1);
    rx = '0; oe_bits = '0; busy_mid = 1'b0; rst_snap = '0;
    set_cs(d, 1'b0);
    half_period();
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_snap = {get_miso(d), get_oe(d), get_busy(d), get_abort(d)};
        rst_n = 1'b1;
      end
      if (cpha) set_sclk(d, ~cpol);
      set_mosi(d, tx[nbits-1-i]);
      half_period();
      rx[nbits-1-i]      = get_miso(d);
      oe_bits[nbits-1-i] = get_oe(d);
      if (i == nbits / 2) busy_mid = get_busy(d);
      set_sclk(d, cpha ? cpol : ~cpol);
      half_period();
      if (!cpha) set_sclk(d, cpol);
    end
    set_cs(d, 1'b1);
    set_mosi(d, 1'b0);
    half_period();
    half_period();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
    sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0;
    repeat (4) @(negedge clk);
    // Pin activity during reset must not reach the FSM or RAM.
    cs0 = 1'b0; sclk0 = 1'b1; mosi0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso0 got=%b exp=0", miso0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL reset_oe0 got=%b exp=0", oe0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (abort0 !== 8'd0) begin errors++; $display("FAIL reset_abort0 got=%0d exp=0", abort0); end
    checks++; if (st0 !== 3'd0) begin errors++; $display("FAIL reset_state0 got=%0d exp=0", st0); end
    checks++; if ({miso1, oe1, busy1} !== 3'b000) begin errors++; $display("FAIL reset_out1 got=%b exp=000", {miso1, oe1, busy1}); end
    checks++; if (abort1 !== 8'd0) begin errors++; $display("FAIL reset_abort1 got=%0d exp=0", abort1); end
    checks++; if (st1 !== 3'd0) begin errors++; $display("FAIL reset_state1 got=%0d exp=0", st1); end
    cs0 = 1'b1; sclk0 = 1'b0; mosi0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    spi_frame(0, 16, {16'h0, 7'h12, 1'b0, 8'hA5}, -1, rx, oe, bm, snap);
    mem0[7'h12] = 8'hA5;
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got=%b exp=1", bm); end
    exp_q.push_back(mem0[7'h12]);
    spi_frame(0, 16, {16'h0, 7'h12, 1'b1, 8'h00}, -1, rx, oe, bm, snap);
    e = exp_q.pop_front();
    checks++; if (rx[7:0] !== e) begin errors++; $display("FAIL rd_data got=%h exp=%h", rx[7:0], e); end
    checks++; if (oe[15:8] !== 8'h00) begin errors++; $display("FAIL rd_oe_cmd got=%b exp=00000000", oe[15:8]); end
    checks++; if (oe[7:0] !== 8'hFF) begin errors++; $display("FAIL rd_oe_data got=%b exp=11111111", oe[7:0]); end
    checks++; if (oe0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rd_after_cs got oe=%b busy=%b exp 0 0", oe0, busy0); end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    spi_frame(0, 24, {8'h0, 7'h7F, 1'b0, 8'h11, 8'h22}, -1, rx, oe, bm, snap);
    mem0[7'h7F] = 8'h11;
    mem0[7'h00] = 8'h22;
    exp_q.push_back(mem0[7'h7F]);
    exp_q.push_back(mem0[7'h00]);
    spi_frame(0, 24, {8'h0, 7'h7F, 1'b1, 16'h0}, -1, rx, oe, bm, snap);
    e = exp_q.pop_front();
    checks++; if (rx[15:8] !== e) begin errors++; $display("FAIL burst_rd0 got=%h exp=%h", rx[15:8], e); end
    e = exp_q.pop_front();
    checks++; if (rx[7:0] !== e) begin errors++; $display("FAIL burst_rd1_wrap got=%h exp=%h", rx[7:0], e); end
  endtask

  task automatic test_abort();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    spi_frame(0, 16, {16'h0, 7'h04, 1'b0, 8'h5A}, -1, rx, oe, bm, snap);
    mem0[7'h04] = 8'h5A;
    spi_frame(0, 11, {21'h0, 7'h04, 1'b0, 3'b101}, -1, rx, oe, bm, snap);
    checks++; if (abort0 !== 8'd1) begin errors++; $display("FAIL abort_count got=%0d exp=1", abort0); end
    exp_q.push_back(mem0[7'h04]);
    spi_frame(0, 16, {16'h0, 7'h04, 1'b1, 8'h00}, -1, rx, oe, bm, snap);
    e = exp_q.pop_front();
    checks++; if (rx[7:0] !== e) begin errors++; $display("FAIL abort_ram_kept got=%h exp=%h", rx[7:0], e); end
    checks++; if (abort0 !== 8'd1) begin errors++; $display("FAIL abort_after_full got=%0d exp=1", abort0); end
  endtask

  task automatic test_mode3_single();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    spi_frame(1, 16, {16'h0, 7'h05, 1'b0, 8'h3C}, -1, rx, oe, bm, snap);
    mem1[7'h05] = 8'h3C;
    exp_q.push_back(mem1[7'h05]);
    spi_frame(1, 24, {8'h0, 7'h05, 1'b1, 16'h0}, -1, rx, oe, bm, snap);
    e = exp_q.pop_front();
    checks++; if (rx[15:8] !== e) begin errors++; $display("FAIL m3_rd got=%h exp=%h", rx[15:8], e); end
    checks++; if (oe[15:8] !== 8'hFF) begin errors++; $display("FAIL m3_oe_first got=%b exp=11111111", oe[15:8]); end
    checks++; if (oe[7:0] !== 8'h00) begin errors++; $display("FAIL m3_oe_second got=%b exp=00000000", oe[7:0]); end
    checks++; if (abort1 !== 8'd0) begin errors++; $display("FAIL m3_abort got=%0d exp=0", abort1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    logic [6:0] base; logic [7:0] d [3];
    for (int r = 0; r < 2; r++) begin
      base = 7'($urandom_range(0, 127));
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom_range(0, 255));
      spi_frame(0, 32, {base, 1'b0, d[0], d[1], d[2]}, -1, rx, oe, bm, snap);
      for (int k = 0; k < 3; k++) mem0[7'(base + 7'(k))] = d[k];
      for (int k = 0; k < 3; k++) exp_q.push_back(mem0[7'(base + 7'(k))]);
      spi_frame(0, 32, {base, 1'b1, 24'h0}, -1, rx, oe, bm, snap);
      for (int k = 0; k < 3; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (rx[23-8*k -: 8] !== e) begin
          errors++;
          $display("FAIL b2b_rd base=%h word=%0d got=%h exp=%h", base, k, rx[23-8*k -: 8], e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rx, oe; logic bm; logic [10:0] snap; logic [7:0] e;
    e = mem0[7'h12];
    spi_frame(0, 16, {16'h0, 7'h12, 1'b1, 8'h00}, 11, rx, oe, bm, snap);
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", bm); end
    checks++; if (rx[7:5] !== e[7:5]) begin errors++; $display("FAIL rstmid_first_bits got=%b exp=%b", rx[7:5], e[7:5]); end
    checks++; if (snap !== 11'd0) begin errors++; $display("FAIL rstmid_reset_vals got=%h exp=000", snap); end
    checks++; if (oe[4:0] !== 5'd0 || rx[4:0] !== 5'd0) begin errors++; $display("FAIL rstmid_no_miso got oe=%b rx=%b exp 0", oe[4:0], rx[4:0]); end
    checks++; if (abort0 !== 8'd0) begin errors++; $display("FAIL rstmid_abort got=%0d exp=0", abort0); end
    exp_q.push_back(mem0[7'h12]);
    spi_frame(0, 16, {16'h0, 7'h12, 1'b1, 8'h00}, -1, rx, oe, bm, snap);
    e = exp_q.pop_front();
    checks++; if (rx[7:0] !== e) begin errors++; $display("FAIL rstmid_next_rd got=%h exp=%h", rx[7:0], e); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_abort();
    test_mode3_single();
    test_back_to_back();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
